// File: rtl/mc_state_ctrl.sv
// rtl/mc_state_ctrl.sv - multi-cycle processor control state machine
module mc_state_ctrl #(
    parameter int STATE_LEN = 3,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 zero,
    output logic [STATE_LEN-1:0] state,
    output logic [31:0]          ir,
    output logic [5:0]           opcode,
    output logic [5:0]           funct,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 illegal,
    output logic [CNT_W-1:0]     instr_count
);

    typedef enum logic [STATE_LEN-1:0] {
        S_IF   = STATE_LEN'(0),
        S_ID   = STATE_LEN'(1),
        S_EX   = STATE_LEN'(2),
        S_MEM  = STATE_LEN'(3),
        S_WB   = STATE_LEN'(4),
        S_HALT = STATE_LEN'(5)
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;

    state_t             state_q, state_d;
    logic [31:0]        ir_q, ir_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;

    logic               ir_write_c;
    logic               pc_write_c;
    logic [1:0]         pc_src_c;
    logic               retire;
    logic               funct_ok;
    logic               supported;

    // Decode looks only at the latched instruction, never at the live bus.
    always_comb begin
        funct_ok = 1'b0;
        case (ir_q[5:0])
            FN_ADD, FN_SUB, FN_AND, FN_OR: funct_ok = 1'b1;
            default:                       funct_ok = 1'b0;
        endcase
        supported = 1'b0;
        case (ir_q[31:26])
            OP_R:                                        supported = funct_ok;
            OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LW, OP_SW: supported = 1'b1;
            default:                                     supported = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        illegal_d  = illegal_q;
        ir_write_c = 1'b0;
        pc_write_c = 1'b0;
        pc_src_c   = 2'b00;
        retire     = 1'b0;

        case (state_q)
            S_IF: begin
                if (imem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    ir_d       = instr;
                    state_d    = S_ID;
                end
            end
            S_ID: begin
                if (!supported) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else if (ir_q[31:26] == OP_J) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = 2'b10;
                    retire     = 1'b1;
                    state_d    = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                if (ir_q[31:26] == OP_BEQ) begin
                    pc_write_c = zero;
                    pc_src_c   = 2'b01;
                    retire     = 1'b1;
                    state_d    = S_IF;
                end else if (ir_q[31:26] == OP_LW || ir_q[31:26] == OP_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (ir_q[31:26] == OP_SW) begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_IF;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IF;
            end
        endcase

        instr_count_d = instr_count_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IF;
            ir_q          <= '0;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Strobes are Mealy on imem_ready, so they must be masked while reset is held.
    assign ir_write    = ir_write_c & rst_n;
    assign pc_write    = pc_write_c & rst_n;
    assign pc_src      = rst_n ? pc_src_c : 2'b00;

    assign state       = state_q;
    assign ir          = ir_q;
    assign opcode      = ir_q[31:26];
    assign funct       = ir_q[5:0];
    assign illegal     = illegal_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mc_state_ctrl.sv
// tb/tb_mc_state_ctrl.sv - directed scoreboard bench for mc_state_ctrl
module tb_mc_state_ctrl;

    localparam int CNT_W = 32;
    localparam logic [2:0] IF = 3'd0, ID = 3'd1, EX = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       instr;
    logic              imem_ready;
    logic              dmem_ready;
    logic              zero;
    logic [2:0]        state;
    logic [31:0]       ir;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic              ir_write;
    logic              pc_write;
    logic [1:0]        pc_src;
    logic              illegal;
    logic [CNT_W-1:0]  instr_count;

    typedef struct {
        logic [2:0] st;
        logic       irw;
        logic       pcw;
        logic [1:0] src;
    } row_t;

    row_t             exp_q[$];
    int               total = 0;
    int               bad   = 0;
    logic [CNT_W-1:0] exp_cnt;

    mc_state_ctrl #(.STATE_LEN(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .zero(zero), .state(state), .ir(ir),
        .opcode(opcode), .funct(funct), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic void push(input logic [2:0] st, input logic irw, input logic pcw,
                                 input logic [1:0] src);
        row_t r;
        r.st = st; r.irw = irw; r.pcw = pcw; r.src = src;
        exp_q.push_back(r);
    endfunction

    // Compare one cycle's expected row mid-cycle, then advance past the next edge.
    task automatic step();
        row_t r;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard observed=empty expected=row");
        end else begin
            r = exp_q.pop_front();
            chk("state", 32'(state), 32'(r.st));
            chk("ir_write", 32'(ir_write), 32'(r.irw));
            chk("pc_write", 32'(pc_write), 32'(r.pcw));
            chk("pc_src", 32'(pc_src), 32'(r.src));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] w);
        instr      = w;
        imem_ready = 1'b1;
        push(IF, 1'b1, 1'b1, 2'b00);
        step();
        imem_ready = 1'b0;
        instr      = 32'hFFFF_FFFF;
        chk("ir_load", ir, w);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'(IF));
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_ir", ir, 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        instr      = 32'h0022_1820;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        zero       = 1'b0;
        exp_cnt    = '0;

        #12;
        chk("reset_state", 32'(state), 32'(IF));
        chk("reset_ir", ir, 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        chk("reset_count", instr_count, 32'd0);
        chk("reset_ir_write", 32'(ir_write), 32'd0);
        chk("reset_pc_write", 32'(pc_write), 32'd0);
        chk("reset_pc_src", 32'(pc_src), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADD: IF, ID, EX, WB
        fetch(32'h0022_1820);
        chk("add_opcode", 32'(opcode), 32'h00);
        chk("add_funct", 32'(funct), 32'h20);
        push(ID, 0, 0, 2'b00); push(EX, 0, 0, 2'b00); push(WB, 0, 0, 2'b00);
        steps(3);
        exp_cnt++;
        chk("add_count", instr_count, exp_cnt);
        chk("add_back_if", 32'(state), 32'(IF));

        // LW with dmem_ready low for three MEM cycles: CPI 8
        dmem_ready = 1'b0;
        fetch(32'h8C22_0004);
        push(ID, 0, 0, 2'b00); push(EX, 0, 0, 2'b00);
        for (int i = 0; i < 4; i++) push(MEM, 0, 0, 2'b00);
        push(WB, 0, 0, 2'b00);
        steps(5);
        dmem_ready = 1'b1;
        steps(2);
        exp_cnt++;
        chk("lw_count", instr_count, exp_cnt);
        chk("lw_back_if", 32'(state), 32'(IF));

        // BEQ taken then not taken
        zero = 1'b1;
        fetch(32'h1022_0003);
        push(ID, 0, 0, 2'b00); push(EX, 0, 1, 2'b01);
        steps(2);
        exp_cnt++;
        chk("beq_t_count", instr_count, exp_cnt);
        zero = 1'b0;
        fetch(32'h1022_0003);
        push(ID, 0, 0, 2'b00); push(EX, 0, 0, 2'b01);
        steps(2);
        exp_cnt++;
        chk("beq_nt_count", instr_count, exp_cnt);
        chk("beq_back_if", 32'(state), 32'(IF));

        // J: retires from ID
        fetch(32'h0800_0010);
        push(ID, 0, 1, 2'b10);
        steps(1);
        exp_cnt++;
        chk("j_count", instr_count, exp_cnt);
        chk("j_back_if", 32'(state), 32'(IF));

        // SW retires from MEM, ORI through WB
        fetch(32'hAC22_0004);
        push(ID, 0, 0, 2'b00); push(EX, 0, 0, 2'b00); push(MEM, 0, 0, 2'b00);
        steps(3);
        exp_cnt++;
        chk("sw_count", instr_count, exp_cnt);
        fetch(32'h3422_0005);
        push(ID, 0, 0, 2'b00); push(EX, 0, 0, 2'b00); push(WB, 0, 0, 2'b00);
        steps(3);
        exp_cnt++;
        chk("ori_count", instr_count, exp_cnt);

        // R-type with unsupported funct halts
        fetch(32'h0022_182A);
        push(ID, 0, 0, 2'b00); push(HALT, 0, 0, 2'b00);
        steps(2);
        chk("slt_illegal", 32'(illegal), 32'd1);
        chk("slt_count", instr_count, exp_cnt);
        do_reset();

        // Opcode 111111 halts; fetch pulses in HALT are ignored
        fetch(32'hFC00_0000);
        push(ID, 0, 0, 2'b00);
        steps(1);
        chk("ill_state", 32'(state), 32'(HALT));
        chk("ill_flag", 32'(illegal), 32'd1);
        imem_ready = 1'b1;
        instr      = 32'h0022_1820;
        for (int i = 0; i < 3; i++) push(HALT, 0, 0, 2'b00);
        steps(3);
        imem_ready = 1'b0;
        chk("halt_ir_kept", ir, 32'hFC00_0000);
        chk("halt_illegal", 32'(illegal), 32'd1);
        do_reset();

        // Counter wrap: preload all-ones while idling in IF
        push(IF, 0, 0, 2'b00);
        force dut.instr_count_d = '1;
        step();
        release dut.instr_count_d;
        exp_cnt = '1;
        chk("preload", instr_count, exp_cnt);
        fetch(32'h0022_1820);
        push(ID, 0, 0, 2'b00); push(EX, 0, 0, 2'b00); push(WB, 0, 0, 2'b00);
        steps(3);
        exp_cnt++;
        chk("wrap_count", instr_count, exp_cnt);

        // Reset in the middle of a stalled MEM cycle abandons the LW
        dmem_ready = 1'b0;
        fetch(32'h8C22_0004);
        push(ID, 0, 0, 2'b00); push(EX, 0, 0, 2'b00); push(MEM, 0, 0, 2'b00);
        steps(3);
        chk("mid_mem_state", 32'(state), 32'(MEM));
        do_reset();
        dmem_ready = 1'b1;
        chk("post_rst_count", instr_count, 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
